cbus_sram_responder: RTL and testbench
======================================

# cbus_sram_responder

Synthesizable cbus responder backing a word-addressed SRAM array. It terminates the cbus request/response interface at the memory end, downstream of the PMP checker and cbus arbiter, and is driven by `cbus_req_t` exactly as a real memory controller would be. It serves single and burst reads and writes with a programmable first-beat latency, and also serves as the deterministic memory model for core and PMP benches.

## Interface
- `DEPTH_WORDS`, 1024: number of 64-bit words; power of two.
- `BASE_ADDR`, 64'h0: byte address mapped to word 0.
- `LATENCY`, 2: wait cycles between request acceptance and the first data beat; 0–15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  `cbus_req_t`  request fields: `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `resp`  out  `cbus_resp_t`  response fields: `ready`, `last`, `data`.
- `busy`  out  1  a transaction is in progress (state ≠ IDLE).
- `err_count`  out  16  saturating count of out-of-range beats.

## Operation
- FSM states: IDLE, WAIT, BEAT, DONE.
- **IDLE**
  - With `req.valid`=1: latch `addr`, `len`, `is_write`, `burst`; clear beat counter `bc`; load wait counter `wc`=LATENCY.
  - Next state: WAIT, or BEAT if LATENCY=0.
- **WAIT**
  - Decrement `wc` each cycle.
  - When `wc`=1, move to BEAT, so the first beat comes exactly LATENCY cycles after acceptance.
- **BEAT**
  - `resp.ready`=1 every cycle; one beat per cycle.
  - Beat address is `addr` + 8·`bc` for INCR and `addr` for FIXED. Word index = (beat addr − BASE_ADDR)[log2(DEPTH_WORDS)+2:3]. Low 3 address bits are ignored.
  - Read: `resp.data` = mem[index], read combinationally in the same cycle.
  - Write: on the clock edge, update mem[index] byte lane i from `req.data` only where `req.strobe[i]`=1. The initiator presents new data/strobe after each ready beat.
  - Beat count is `len`+1, where `mlen_t` is 4 bits (1–16 beats). `resp.last`=1 on the beat where `bc`=`len`; next state is DONE.
  - Out-of-range beat (beat addr < BASE_ADDR or ≥ BASE_ADDR + 8·DEPTH_WORDS):
    - Handshake still completes.
    - Read data = 0; the write is dropped.
    - `err_count`++, saturating at 16'hFFFF.
- **DONE**
  - ready=0.
  - Return to IDLE once `req.valid`=0. A `valid` still held high here is treated as the tail of the finished request, not a new request.
- **Protocol violation:** if `req.valid` falls in WAIT or BEAT, abort to IDLE with no further writes. ready and last drop in the same cycle.

## Timing
- Reset values: `resp.ready`=0, `resp.last`=0, `resp.data`=0, `busy`=0, `err_count`=0, state IDLE.
- Reset does not clear memory contents.
- Reset asserted mid-burst: outputs return to reset values asynchronously, and no write occurs on that edge. Beats already written stay written.
- Latency: `valid` rises at cycle t.
  - First ready at t+1+LATENCY.
  - Last ready at t+1+LATENCY+`len`.
  - Earliest next acceptance at t+3+LATENCY+`len`, which assumes `valid` drops the cycle after last.
- `resp.data` and `resp.last` are valid only while `resp.ready`=1; otherwise `data`=0 and `last`=0.
- INCR bursts that cross the top of the array go out of range for the remaining beats. There is no wrap.

## Structure
- `cbus_req_t`, `cbus_resp_t`, `mlen_t`, `msize_t`, burst encodings (INCR/FIXED) and `word_t` come from the shared common package. No new typedefs are added there.
- The FSM state enum is local to the module.
- One natural sub-module: `sram_1r1w_be`, a byte-enabled array with asynchronous read and synchronous write. It is replaceable by a vendor macro when LATENCY ≥ 1 permits a registered read.

## Test plan
- **Single read:** preload mem[1]=64'hDEADBEEF, LATENCY=2; read `addr`=0x8, `len`=0 → ready at t+3 with data 64'hDEADBEEF and last=1; ready=0 afterwards.
- **INCR burst write then read:** `len`=3, data 1,2,3,4, strobe 8'hFF at 0x100; then read the same range → four consecutive ready beats 1,2,3,4, last on the 4th beat; `busy` falls after DONE.
- **Strobe write:** mem[0]=0; write 64'h1122334455667788 with strobe 8'h0F → read returns 64'h0000000055667788.
- **Out of range:** DEPTH_WORDS=1024; read 0x5000 → handshake completes, data 0, `err_count`=1. An INCR `len`=3 burst at 0x1FF0 → beats 3–4 out of range, `err_count`=3.
- **FIXED burst, LATENCY=0:** `len`=2 write of 7, 8, 9 to 0x40 → mem[8]=9; ready is asserted in the cycle right after `valid` rises.
- **Reset mid-burst:** assert `reset`=0 during beat 2 of a 4-beat write → ready=0 immediately; mem holds beats 0–1 only; the FSM is in IDLE after release.

Source files
------------

// File: rtl/cbus_sram_responder_pkg.sv
// cbus_sram_responder_pkg: cbus request/response types shared by the SRAM
// responder and its benches.
//   word_t      64-bit data word
//   mlen_t      burst length minus one (1..16 beats)
//   msize_t     access size code (carried, not interpreted by the responder)
//   mburst_t    burst type: FIXED repeats the address, INCR steps by a word
//   cbus_req_t  initiator -> responder request
//   cbus_resp_t responder -> initiator response
package cbus_sram_responder_pkg;

  typedef logic [63:0] word_t;
  typedef logic [3:0]  mlen_t;
  typedef logic [2:0]  msize_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1
  } mburst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    word_t       data;
    mlen_t       len;
    mburst_t     burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  localparam int unsigned WORD_BYTES = 8;

endpackage

// File: rtl/cbus_sram_responder_sram_1r1w_be.sv
// sram_1r1w_be: word array with byte-enabled synchronous write and
// asynchronous read. Contents are never reset.
//   clk    rising-edge clock
//   we     write enable
//   waddr  write word index
//   wstrb  per-byte write enables (bit i -> bits 8i+7:8i)
//   wdata  write data
//   raddr  read word index
//   rdata  read data, combinational from raddr
module sram_1r1w_be
  import cbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_BYTES-1:0] wstrb,
  input  word_t                 wdata,
  input  logic [AW-1:0]         raddr,
  output word_t                 rdata
);

  logic [WORD_BYTES-1:0][7:0] mem [0:DEPTH-1];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wstrb[i]) mem[waddr][i] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// cbus_sram_responder: cbus slave terminating single and burst reads/writes
// into a word-addressed SRAM, first beat LATENCY cycles after acceptance.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req        cbus request (valid, is_write, size, addr, strobe, data, len, burst)
//   resp       cbus response (ready, last, data)
//   busy       high whenever a transaction is in progress
//   err_count  saturating count of out-of-range beats
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic       busy,
  output logic [15:0] err_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

  state_t      state;
  logic [63:0] addr_q;
  mlen_t       len_q;
  mlen_t       bc;
  logic        wr_q;
  mburst_t     burst_q;
  logic [3:0]  wc;

  logic [63:0] beat_addr;
  logic [63:0] offset;
  logic        in_range;
  logic        beat;
  word_t       rdata;

  assign beat_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + {57'd0, bc, 3'd0};
  assign offset    = beat_addr - BASE_ADDR;
  // Offset beyond the array (including wrap from beat_addr < BASE_ADDR) leaves
  // high bits set; INCR bursts running off the top simply go out of range.
  assign in_range  = (beat_addr >= BASE_ADDR) && (offset[63:AW+3] == '0);
  // Ready is combinational on valid so a dropped valid kills the beat at once.
  assign beat      = (state == S_BEAT) && req.valid;

  sram_1r1w_be #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (beat && wr_q && in_range),
    .waddr (offset[AW+2:3]),
    .wstrb (req.strobe),
    .wdata (req.data),
    .raddr (offset[AW+2:3]),
    .rdata (rdata)
  );

  assign resp.ready = beat;
  assign resp.last  = beat && (bc == len_q);
  assign resp.data  = (beat && !wr_q && in_range) ? rdata : '0;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wr_q      <= 1'b0;
      burst_q   <= BURST_INCR;
      bc        <= '0;
      wc        <= '0;
      err_count <= '0;
    end else begin
      if (beat && !in_range && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      unique case (state)
        S_IDLE: if (req.valid) begin
          addr_q  <= req.addr;
          len_q   <= req.len;
          wr_q    <= req.is_write;
          burst_q <= req.burst;
          bc      <= '0;
          wc      <= 4'(LATENCY);
          state   <= (LATENCY == 0) ? S_BEAT : S_WAIT;
        end
        S_WAIT: if (!req.valid) state <= S_IDLE;
          else begin
            wc <= wc - 4'd1;
            if (wc == 4'd1) state <= S_BEAT;
          end
        S_BEAT: if (!req.valid) state <= S_IDLE;
          else if (bc == len_q) state <= S_DONE;
          else bc <= bc + 4'd1;
        // A still-high valid is the tail of the finished request.
        S_DONE: if (!req.valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{req.size, offset[2:0]};

endmodule

// File: tb/tb_cbus_sram_responder.sv
// tb_cbus_sram_responder: directed bench for cbus_sram_responder. Two
// instances (LATENCY=2 and LATENCY=0) share one request bus; only the
// selected one sees valid.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_req_t  req, req_l2, req_l0;
  cbus_resp_t resp_l2, resp_l0, resp;
  logic       busy_l2, busy_l0, busy;
  logic [15:0] err_l2, err_l0;
  logic       sel_l0;

  always_comb begin
    req_l2 = req;
    req_l2.valid = req.valid & ~sel_l0;
    req_l0 = req;
    req_l0.valid = req.valid & sel_l0;
  end
  assign resp = sel_l0 ? resp_l0 : resp_l2;
  assign busy = sel_l0 ? busy_l0 : busy_l2;

  cbus_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(64'h0), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req_l2), .resp(resp_l2), .busy(busy_l2), .err_count(err_l2));

  cbus_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(64'h0), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_l0), .resp(resp_l0), .busy(busy_l0), .err_count(err_l0));

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction with cycle-exact ready/last/data/busy checks.
  // d holds write data, or expected read data for reads.
  task automatic xact(input string tag, input bit l0, input bit wr, input logic [63:0] a,
                      input int len, input mburst_t bm, input logic [7:0] strb, input word_t d [4]);
    int lat;
    lat = l0 ? 0 : 2;
    @(negedge clk);
    sel_l0 = l0;
    req.valid = 1'b1; req.is_write = wr; req.addr = a; req.len = mlen_t'(len);
    req.burst = bm; req.strobe = strb; req.data = d[0]; req.size = 3'd3;
    @(posedge clk);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); #1;
      check({tag, " wait ready"}, {63'd0, resp.ready}, 64'd0);
      check({tag, " wait busy"}, {63'd0, busy}, 64'd1);
      @(posedge clk);
    end
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      req.data = d[k];
      #1;
      check({tag, " beat ready"}, {63'd0, resp.ready}, 64'd1);
      check({tag, " beat last"}, {63'd0, resp.last}, (k == len) ? 64'd1 : 64'd0);
      if (!wr) check({tag, " beat data"}, resp.data, d[k]);
      @(posedge clk);
    end
    @(negedge clk);
    req.valid = 1'b0;
    #1;
    check({tag, " done ready"}, {63'd0, resp.ready}, 64'd0);
    check({tag, " done busy"}, {63'd0, busy}, 64'd1);
    @(negedge clk); #1;
    check({tag, " idle busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    req = '0;
    req.burst = BURST_INCR;
    sel_l0 = 1'b0;
    reset = 1'b0;
    #12;
    check("rst ready", {63'd0, resp_l2.ready}, 64'd0);
    check("rst last", {63'd0, resp_l2.last}, 64'd0);
    check("rst data", resp_l2.data, 64'd0);
    check("rst busy", {63'd0, busy_l2}, 64'd0);
    check("rst err", {48'd0, err_l2}, 64'd0);
    check("rst busy0", {63'd0, busy_l0}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single read of a preloaded word.
    xact("pre1", 0, 1, 64'h8, 0, BURST_INCR, 8'hFF, '{64'hDEADBEEF, 0, 0, 0});
    xact("rd1", 0, 0, 64'h8, 0, BURST_INCR, 8'hFF, '{64'hDEADBEEF, 0, 0, 0});

    // INCR burst write then read back.
    xact("wrb", 0, 1, 64'h100, 3, BURST_INCR, 8'hFF, '{64'd1, 64'd2, 64'd3, 64'd4});
    xact("rdb", 0, 0, 64'h100, 3, BURST_INCR, 8'hFF, '{64'd1, 64'd2, 64'd3, 64'd4});

    // Partial-strobe write.
    xact("clr0", 0, 1, 64'h0, 0, BURST_INCR, 8'hFF, '{64'd0, 0, 0, 0});
    xact("stb", 0, 1, 64'h0, 0, BURST_INCR, 8'h0F, '{64'h1122334455667788, 0, 0, 0});
    xact("rdstb", 0, 0, 64'h0, 0, BURST_INCR, 8'hFF, '{64'h0000000055667788, 0, 0, 0});
    check("err none", {48'd0, err_l2}, 64'd0);

    // Out of range: single read, then INCR burst running off the top.
    xact("oor rd", 0, 0, 64'h5000, 0, BURST_INCR, 8'hFF, '{64'd0, 0, 0, 0});
    check("err oor1", {48'd0, err_l2}, 64'd1);
    xact("oor wr", 0, 1, 64'h1FF0, 3, BURST_INCR, 8'hFF, '{64'h11, 64'h22, 64'h33, 64'h44});
    check("err oor3", {48'd0, err_l2}, 64'd3);
    xact("oor rdb", 0, 0, 64'h1FF0, 3, BURST_INCR, 8'hFF, '{64'h11, 64'h22, 64'd0, 64'd0});
    check("err oor5", {48'd0, err_l2}, 64'd5);

    // FIXED burst on the zero-latency instance.
    xact("fix wr", 1, 1, 64'h40, 2, BURST_FIXED, 8'hFF, '{64'd7, 64'd8, 64'd9, 0});
    xact("fix rd", 1, 0, 64'h40, 0, BURST_INCR, 8'hFF, '{64'd9, 0, 0, 0});
    check("err l0", {48'd0, err_l0}, 64'd0);

    // Reset during beat 2 of a 4-beat write.
    xact("rz", 0, 1, 64'h200, 3, BURST_INCR, 8'hFF, '{64'd0, 64'd0, 64'd0, 64'd0});
    @(negedge clk);
    sel_l0 = 1'b0;
    req.valid = 1'b1; req.is_write = 1'b1; req.addr = 64'h200; req.len = 4'd3;
    req.burst = BURST_INCR; req.strobe = 8'hFF; req.data = 64'hA0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); req.data = 64'hA0; @(posedge clk);
    @(negedge clk); req.data = 64'hA1; @(posedge clk);
    @(negedge clk); req.data = 64'hA2; #1;
    check("rmid ready before", {63'd0, resp.ready}, 64'd1);
    reset = 1'b0;
    #1;
    check("rmid ready", {63'd0, resp.ready}, 64'd0);
    check("rmid last", {63'd0, resp.last}, 64'd0);
    check("rmid busy", {63'd0, busy}, 64'd0);
    check("rmid err", {48'd0, err_l2}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    req.valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rmid idle", {63'd0, busy}, 64'd0);
    xact("rmid rd", 0, 0, 64'h200, 3, BURST_INCR, 8'hFF, '{64'hA0, 64'hA1, 64'd0, 64'd0});

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
